// File: rtl/axi_4_pkg.sv
// Shared AXI4 channel types, response/burst encodings and the slave FSM state
// type for axi4_slave_mem.
package axi_4_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic [3:0]  id;
  } addr_chan_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
  } wr_data_chan_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [3:0]  id;
  } rd_data_chan_t;

  typedef struct packed {
    logic [1:0] resp;
    logic [3:0] id;
  } wr_resp_chan_t;

  typedef enum logic [2:0] {
    IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_DATA, WR_RESP
  } state_t;

  // Beat-to-beat address step. WRAP is deliberately treated as a plain
  // increment; FIXED and the reserved encoding keep the address.
  function automatic logic [31:0] next_addr(input logic [31:0] a, input logic [1:0] burst);
    case (burst)
      BURST_INCR, BURST_WRAP: return a + 32'd4;
      default:                return a;
    endcase
  endfunction

endpackage

// File: rtl/axi_mem_array.sv
// Single-port word memory: byte-strobed write, registered read, both gated
// by one enable. Contents are never reset.
module axi_mem_array #(
  parameter int DEPTH = 1024,
  parameter int IDX_W = 10
) (
  input  logic             clk,
  input  logic             en,
  input  logic [3:0]       we,
  input  logic [IDX_W-1:0] addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata
);

  logic [31:0] mem [DEPTH];

  // Port access: selected bytes written, old word captured into rdata
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 4; i++) begin
        if (we[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/axi4_slave_mem.sv
// AXI4 memory slave with a six-state FSM serving one read or write burst at
// a time. Optional macro AXI_MEM_ERR_RESP_EN: beats addressed at or beyond
// MEM_DEPTH*4 bytes return SLVERR (reads give 0, writes are dropped);
// without it the word index wraps modulo MEM_DEPTH and resp is always OKAY.
module axi4_slave_mem
  import axi_4_pkg::*;
#(
  parameter int MEM_DEPTH  = 1024,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ld_req,
  input  logic          st_req,
  input  logic          m_arvalid,
  output logic          s_arready,
  output logic          s_rvalid,
  input  logic          m_rready,
  input  logic          m_awvalid,
  output logic          s_awready,
  input  logic          m_wvalid,
  output logic          s_wready,
  output logic          s_bvalid,
  input  logic          m_bready,
  input  addr_chan_t    re_wr_addr_channel,
  input  wr_data_chan_t wr_data_channel,
  output rd_data_chan_t re_data_channel,
  output wr_resp_chan_t wr_resp_channel
);

  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

`ifdef AXI_MEM_ERR_RESP_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  // Word index of a byte address, wrapped into the array.
  function automatic logic [IDX_W-1:0] word_index(input logic [31:0] a);
    return IDX_W'((32'(a[ADDR_WIDTH-1:0]) >> 2) % 32'(MEM_DEPTH));
  endfunction

  // Beat falls outside the array (only meaningful with error responses on).
  function automatic logic is_oob(input logic [31:0] a);
    return ERR_EN && ((a >> 2) >= 32'(MEM_DEPTH));
  endfunction

  state_t      state, state_nxt;
  logic [31:0] addr_q;
  logic [1:0]  burst_q;
  logic [3:0]  id_q;
  logic [8:0]  cnt_q;
  logic        wr_err_q;
  logic        rd_err_p1;

  logic        ar_hs, r_hs, aw_hs, w_hs, last_beat;
  logic        mem_en, oob_cur;
  logic [3:0]  mem_we;
  logic [31:0] mem_byte_addr, rdata_p1;
  logic        unused_fields;

  assign ar_hs     = (state == RD_ADDR) && m_arvalid;
  assign r_hs      = (state == RD_DATA) && m_rready;
  assign aw_hs     = (state == WR_ADDR) && m_awvalid;
  assign w_hs      = (state == WR_DATA) && m_wvalid;
  assign last_beat = (cnt_q == 9'd1);
  assign oob_cur   = is_oob(mem_byte_addr);
  // Only 32-bit transfers exist, and the beat count decides the last write beat.
  assign unused_fields = ^{re_wr_addr_channel.size, wr_data_channel.last, DATA_WIDTH[0]};

  // Memory port: prefetch first word on AR, next word on each accepted R beat, write on W
  always_comb begin
    mem_en        = 1'b0;
    mem_we        = 4'b0000;
    mem_byte_addr = addr_q;
    if (ar_hs) begin
      mem_en        = 1'b1;
      mem_byte_addr = re_wr_addr_channel.addr;
    end else if (r_hs) begin
      mem_en        = 1'b1;
      mem_byte_addr = next_addr(addr_q, burst_q);
    end else if (w_hs) begin
      mem_en        = 1'b1;
      mem_we        = is_oob(addr_q) ? 4'b0000 : wr_data_channel.strb;
    end
  end

  axi_mem_array #(
    .DEPTH (MEM_DEPTH),
    .IDX_W (IDX_W)
  ) u_mem (
    .clk   (clk),
    .en    (mem_en),
    .we    (mem_we),
    .addr  (word_index(mem_byte_addr)),
    .wdata (wr_data_channel.data),
    .rdata (rdata_p1)
  );

  // Burst bookkeeping: latch on address handshake, step on every data beat
  always_ff @(posedge clk) begin
    if (ar_hs || aw_hs) begin
      addr_q   <= re_wr_addr_channel.addr;
      burst_q  <= re_wr_addr_channel.burst;
      id_q     <= re_wr_addr_channel.id;
      cnt_q    <= {1'b0, re_wr_addr_channel.len} + 9'd1;
      wr_err_q <= 1'b0;
    end else if (r_hs || w_hs) begin
      addr_q   <= next_addr(addr_q, burst_q);
      cnt_q    <= cnt_q - 9'd1;
      wr_err_q <= wr_err_q | (w_hs & oob_cur);
    end
    if (mem_en) rd_err_p1 <= oob_cur;
  end

  // State register; reset aborts any burst in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next state and all handshake/channel outputs, zero outside their states
  always_comb begin
    state_nxt       = state;
    s_arready       = 1'b0;
    s_rvalid        = 1'b0;
    s_awready       = 1'b0;
    s_wready        = 1'b0;
    s_bvalid        = 1'b0;
    re_data_channel = '0;
    wr_resp_channel = '0;
    case (state)
      IDLE: begin
        if (ld_req)      state_nxt = RD_ADDR;
        else if (st_req) state_nxt = WR_ADDR;
      end
      RD_ADDR: begin
        s_arready = 1'b1;
        if (m_arvalid) state_nxt = RD_DATA;
      end
      RD_DATA: begin
        s_rvalid             = 1'b1;
        re_data_channel.data = rd_err_p1 ? 32'd0 : rdata_p1;
        re_data_channel.resp = rd_err_p1 ? RESP_SLVERR : RESP_OKAY;
        re_data_channel.last = last_beat;
        re_data_channel.id   = id_q;
        if (m_rready && last_beat) state_nxt = IDLE;
      end
      WR_ADDR: begin
        s_awready = 1'b1;
        if (m_awvalid) state_nxt = WR_DATA;
      end
      WR_DATA: begin
        s_wready = 1'b1;
        if (m_wvalid && last_beat) state_nxt = WR_RESP;
      end
      WR_RESP: begin
        s_bvalid             = 1'b1;
        wr_resp_channel.resp = wr_err_q ? RESP_SLVERR : RESP_OKAY;
        wr_resp_channel.id   = id_q;
        if (m_bready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi4_slave_mem.sv
// Randomised self-checking bench for axi4_slave_mem against a word-array
// reference model. Honours AXI_MEM_ERR_RESP_EN when it is defined.
module tb_axi4_slave_mem;
  import axi_4_pkg::*;

  localparam int DEPTH = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic          ld_req, st_req, m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready;
  logic          s_arready, s_rvalid, s_awready, s_wready, s_bvalid;
  addr_chan_t    ax;
  wr_data_chan_t w;
  rd_data_chan_t r;
  wr_resp_chan_t b;

  int checks = 0;
  int errors = 0;

  logic [31:0] ref_mem [DEPTH];
  logic [31:0] wdat [16];
  logic [3:0]  wstrb [16];

  axi4_slave_mem #(.MEM_DEPTH(DEPTH)) dut (
    .clk                (clk),
    .reset              (reset),
    .ld_req             (ld_req),
    .st_req             (st_req),
    .m_arvalid          (m_arvalid),
    .s_arready          (s_arready),
    .s_rvalid           (s_rvalid),
    .m_rready           (m_rready),
    .m_awvalid          (m_awvalid),
    .s_awready          (s_awready),
    .m_wvalid           (m_wvalid),
    .s_wready           (s_wready),
    .s_bvalid           (s_bvalid),
    .m_bready           (m_bready),
    .re_wr_addr_channel (ax),
    .wr_data_channel    (w),
    .re_data_channel    (r),
    .wr_resp_channel    (b)
  );

  always #5 clk = ~clk;

  // ---------------- reference model rules ----------------
  function automatic logic [31:0] beat_addr(input logic [31:0] a, input logic [1:0] bt, input int i);
    return (bt == 2'b00) ? a : a + 32'(4 * i);
  endfunction

  function automatic int widx(input logic [31:0] a);
    return int'((a / 4) % DEPTH);
  endfunction

  function automatic bit oob(input logic [31:0] a);
`ifdef AXI_MEM_ERR_RESP_EN
    return (a / 4) >= DEPTH;
`else
    return 1'b0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ld_req = 0; st_req = 0; m_arvalid = 0; m_rready = 0;
    m_awvalid = 0; m_wvalid = 0; m_bready = 0;
    ax = '0; w = '0;
  endtask

  task automatic do_write(input logic [31:0] a, input int len, input logic [1:0] bt,
                          input logic [3:0] id, input string tag);
    int n;
    bit err_exp;
    logic [31:0] ba;
    logic [1:0] exp_resp;
    err_exp = 0;
    st_req = 1;
    n = 0;
    while (!s_awready && n < 20) begin tick(); n++; end
    checks++;
    if (s_awready !== 1'b1) begin
      errors++;
      $display("FAIL %s awready_wait: got %b, required 1", tag, s_awready);
      idle_inputs();
      return;
    end
    st_req = 0;
    m_awvalid = 1;
    ax = '{addr: a, len: 8'(len), size: 3'($urandom), burst: bt, id: id};
    tick();
    m_awvalid = 0;
    ax = '0;
    for (int i = 0; i <= len; i++) begin
      if ($urandom_range(0, 3) == 0) begin m_wvalid = 0; tick(); end
      checks++;
      if (s_wready !== 1'b1) begin
        errors++;
        $display("FAIL %s wready beat %0d: got %b, required 1", tag, i, s_wready);
      end
      m_wvalid = 1;
      w = '{data: wdat[i], strb: wstrb[i], last: 1'($urandom)};
      ba = beat_addr(a, bt, i);
      if (oob(ba)) err_exp = 1;
      else begin
        for (int j = 0; j < 4; j++)
          if (wstrb[i][j]) ref_mem[widx(ba)][8*j +: 8] = wdat[i][8*j +: 8];
      end
      tick();
    end
    m_wvalid = 0;
    w = '0;
    exp_resp = err_exp ? 2'b10 : 2'b00;
    checks++;
    if (s_bvalid !== 1'b1 || b !== '{resp: exp_resp, id: id}) begin
      errors++;
      $display("FAIL %s bresp: got bvalid=%b resp=%b id=%h, required bvalid=1 resp=%b id=%h",
               tag, s_bvalid, b.resp, b.id, exp_resp, id);
    end
    repeat ($urandom_range(0, 2)) tick();
    checks++;
    if (s_bvalid !== 1'b1 || b.resp !== exp_resp) begin
      errors++;
      $display("FAIL %s bresp_hold: got bvalid=%b resp=%b, required 1 %b", tag, s_bvalid, b.resp, exp_resp);
    end
    m_bready = 1;
    tick();
    m_bready = 0;
    checks++;
    if (s_bvalid !== 1'b0) begin
      errors++;
      $display("FAIL %s bvalid_drop: got %b, required 0", tag, s_bvalid);
    end
  endtask

  task automatic do_read(input logic [31:0] a, input int len, input logic [1:0] bt,
                         input logic [3:0] id, input int stall, input bit both, input string tag);
    int n, h;
    logic [31:0] ba;
    rd_data_chan_t exp;
    ld_req = 1;
    st_req = both;
    n = 0;
    while (!s_arready && n < 20) begin tick(); n++; end
    checks++;
    if (s_arready !== 1'b1 || s_awready !== 1'b0) begin
      errors++;
      $display("FAIL %s ar_select: got arready=%b awready=%b, required 1 0", tag, s_arready, s_awready);
      idle_inputs();
      return;
    end
    ld_req = 0;
    st_req = 0;
    m_arvalid = 1;
    ax = '{addr: a, len: 8'(len), size: 3'($urandom), burst: bt, id: id};
    tick();
    m_arvalid = 0;
    ax = '0;
    for (int i = 0; i <= len; i++) begin
      ba = beat_addr(a, bt, i);
      exp.data = oob(ba) ? 32'd0 : ref_mem[widx(ba)];
      exp.resp = oob(ba) ? 2'b10 : 2'b00;
      exp.last = (i == len);
      exp.id   = id;
      checks++;
      if (s_rvalid !== 1'b1 || r !== exp) begin
        errors++;
        $display("FAIL %s rbeat %0d: got rvalid=%b chan=%h, required rvalid=1 chan=%h", tag, i, s_rvalid, r, exp);
      end
      h = (stall >= 0 && i == 0) ? stall : $urandom_range(0, 2);
      m_rready = 0;
      repeat (h) begin
        tick();
        checks++;
        if (s_rvalid !== 1'b1 || r !== exp) begin
          errors++;
          $display("FAIL %s rhold %0d: got rvalid=%b chan=%h, required rvalid=1 chan=%h", tag, i, s_rvalid, r, exp);
        end
      end
      m_rready = 1;
      tick();
      m_rready = 0;
    end
    checks++;
    if (s_rvalid !== 1'b0) begin
      errors++;
      $display("FAIL %s rbeat_count: rvalid=%b after %0d beats, required 0", tag, s_rvalid, len + 1);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle_inputs();
    reset = 1;
    ld_req = 1;
    repeat (3) tick();
    checks++;
    if ({s_arready, s_rvalid, s_awready, s_wready, s_bvalid} !== 5'b0 || r !== '0 || b !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got ready/valid=%b r=%h b=%h, required all 0",
               {s_arready, s_rvalid, s_awready, s_wready, s_bvalid}, r, b);
    end
    ld_req = 0;
    reset = 0;
    tick();
  endtask

  task automatic test_init();
    for (int k = 0; k < DEPTH / 16; k++) begin
      for (int i = 0; i < 16; i++) begin wdat[i] = $urandom; wstrb[i] = 4'hF; end
      do_write(32'(k * 64), 15, BURST_INCR, 4'(k), "init");
    end
  endtask

  task automatic test_single_read();
    wdat[0] = 32'hDEADBEEF; wstrb[0] = 4'hF;
    do_write(32'h10, 0, BURST_INCR, 4'h3, "single_wr");
    do_read(32'h10, 0, BURST_INCR, 4'h5, 0, 0, "single_rd");
  endtask

  task automatic test_incr_write();
    for (int i = 0; i < 4; i++) begin wdat[i] = 32'(i + 1); wstrb[i] = 4'hF; end
    do_write(32'h20, 3, BURST_INCR, 4'h7, "incr_wr");
    do_read(32'h20, 3, BURST_INCR, 4'h8, -1, 0, "incr_rd");
  endtask

  task automatic test_strobe();
    wdat[0] = 32'h11223344; wstrb[0] = 4'hF;
    do_write(32'h30, 0, BURST_INCR, 4'h1, "strb_base");
    wdat[0] = 32'hAABBCCDD; wstrb[0] = 4'b0101;
    do_write(32'h30, 0, BURST_INCR, 4'h2, "strb_part");
    do_read(32'h30, 0, BURST_INCR, 4'h9, 1, 0, "strb_rd");
  endtask

  task automatic test_backpressure();
    do_read(32'h40, 1, BURST_INCR, 4'hA, 3, 0, "backpressure");
  endtask

  task automatic test_priority();
    do_read(32'h50, 0, BURST_INCR, 4'hB, 0, 1, "priority");
  endtask

  task automatic test_fixed_wrap();
    for (int i = 0; i < 4; i++) begin wdat[i] = $urandom; wstrb[i] = 4'(1 << i); end
    do_write(32'h60, 3, BURST_FIXED, 4'hC, "fixed_wr");
    do_read(32'h60, 2, BURST_FIXED, 4'hD, -1, 0, "fixed_rd");
    for (int i = 0; i < 3; i++) begin wdat[i] = $urandom; wstrb[i] = 4'hF; end
    do_write(32'h70, 2, BURST_WRAP, 4'hE, "wrap_wr");
    do_read(32'h70, 2, BURST_WRAP, 4'hF, -1, 0, "wrap_rd");
  endtask

  task automatic test_out_of_range();
    do_read(32'(DEPTH * 4), 0, BURST_INCR, 4'h4, 0, 0, "oob_rd");
    for (int i = 0; i < 3; i++) begin wdat[i] = $urandom; wstrb[i] = 4'hF; end
    do_write(32'(DEPTH * 4 - 8), 2, BURST_INCR, 4'h6, "oob_wr");
    do_read(32'(DEPTH * 4 - 8), 2, BURST_INCR, 4'h6, -1, 0, "oob_rdback");
  endtask

  task automatic test_random();
    logic [31:0] a;
    int len;
    logic [1:0] bt;
    for (int t = 0; t < 40; t++) begin
      a   = 32'($urandom_range(0, DEPTH * 2 - 1) * 4);
      len = $urandom_range(0, 7);
      bt  = 2'($urandom_range(0, 2));
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i <= len; i++) begin wdat[i] = $urandom; wstrb[i] = 4'($urandom); end
        do_write(a, len, bt, 4'($urandom), "rand_wr");
      end else begin
        do_read(a, len, bt, 4'($urandom), -1, 1'($urandom), "rand_rd");
      end
    end
  endtask

  task automatic test_reset_mid_write();
    int n;
    st_req = 1;
    n = 0;
    while (!s_awready && n < 20) begin tick(); n++; end
    checks++;
    if (s_awready !== 1'b1) begin
      errors++;
      $display("FAIL midrst awready_wait: got %b, required 1", s_awready);
      idle_inputs();
      return;
    end
    st_req = 0;
    m_awvalid = 1;
    ax = '{addr: 32'h80, len: 8'd3, size: 3'b010, burst: BURST_INCR, id: 4'h5};
    tick();
    m_awvalid = 0;
    for (int i = 0; i < 2; i++) begin
      w = '{data: $urandom, strb: 4'hF, last: 1'b0};
      m_wvalid = 1;
      ref_mem[widx(32'h80 + 32'(4 * i))] = w.data;
      tick();
    end
    m_wvalid = 0;
    reset = 1;
    #1;
    checks++;
    if ({s_arready, s_rvalid, s_awready, s_wready, s_bvalid} !== 5'b0 || r !== '0 || b !== '0) begin
      errors++;
      $display("FAIL midrst_outputs: got ready/valid=%b r=%h b=%h, required all 0",
               {s_arready, s_rvalid, s_awready, s_wready, s_bvalid}, r, b);
    end
    idle_inputs();
    tick();
    reset = 0;
    repeat (4) begin
      tick();
      checks++;
      if (s_bvalid !== 1'b0 || s_wready !== 1'b0) begin
        errors++;
        $display("FAIL midrst_no_resp: got bvalid=%b wready=%b, required 0 0", s_bvalid, s_wready);
      end
    end
    do_read(32'h80, 3, BURST_INCR, 4'h2, -1, 0, "midrst_rdback");
  endtask

  initial begin
    idle_inputs();
    reset = 1;
    test_reset();
    test_init();
    test_single_read();
    test_incr_write();
    test_strobe();
    test_backpressure();
    test_priority();
    test_fixed_wrap();
    test_out_of_range();
    test_random();
    test_reset_mid_write();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
